md_issue_ctrl: RTL and testbench
================================

Name: md_issue_ctrl

Overview:
- Initiator side of the multiply/divide unit (MDU) handshake.
- Sits in the E stage. Decodes the E-stage MDU operation into the MDU's start/op/operand inputs.
- Tracks MDU occupancy with an internal countdown mirror and generates the D-stage stall.
- Returns HI/LO for mfhi/mflo, suppresses issue on exception request, and flags protocol mismatches and divide-by-zero.

Parameters:
- LAT_MUL, 5, cycles the MDU stays busy after a mult/multu start.
- LAT_DIV, 10, cycles the MDU stays busy after a div/divu start.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. 0 = reset asserted.
- Req  input  1  exception/interrupt request. While 1, no MDU command and no mthi/mtlo is issued.
- E_valid  input  1  E-stage instruction is valid (not a bubble).
- E_md_op  input  4  E-stage MDU class: 0 none, 1 mult, 2 div, 3 mthi, 4 mtlo, 5 mfhi, 6 mflo, 7 multu, 8 divu. Any other code is treated as none.
- E_rs  input  32  forwarded rs value.
- E_rt  input  32  forwarded rt value.
- D_md_use  input  1  D-stage instruction is any MDU class (1-8).
- md_busy  input  1  Busy from the MDU.
- md_hi  input  32  HI from the MDU.
- md_lo  input  32  LO from the MDU.
- md_start  output  1  start pulse to the MDU (combinational).
- md_op  output  4  op to the MDU (combinational).
- md_A  output  32  operand A = E_rs.
- md_B  output  32  operand B = E_rt.
- stall_D  output  1  freeze F/D and insert a bubble in E.
- E_md_rdata  output  32  mfhi returns md_hi, mflo returns md_lo, otherwise 0.
- div0  output  1  sticky; set when a div/divu issues with E_rt==0.
- proto_err  output  1  sticky; set on an md_busy/mirror mismatch.
- stall_cnt  output  32  count of cycles with stall_D=1. Wraps modulo 2^32.

Behaviour:
- Let `iss = E_valid & ~Req & (E_md_op in {1,2,7,8}) & (state==IDLE)`.
  - md_start = iss.
  - md_op = E_md_op when E_valid & ~Req, else 0. This means mthi (3) and mtlo (4) reach the MDU only when Req=0.
  - md_A = E_rs and md_B = E_rt at all times.
- State machine, registered: IDLE, BUSY.
  - IDLE -> BUSY on iss. Load cnt = LAT_MUL for op 1/7, or LAT_DIV for op 2/8.
  - BUSY: cnt decrements by 1 each cycle. Return to IDLE on the edge where cnt==1 is decremented to 0.
- The MDU's busy flag rises one cycle after start. The mirror's BUSY state also covers cycles 1..LAT after start, so the mirror and md_busy stay aligned.
- stall_D = D_md_use & (md_start | state==BUSY).
  - The start cycle is included because HI/LO read as 0 during start and md_busy is not yet 1.
  - The caller guarantees an E-stage MDU op is never issued while BUSY. If one arrives anyway (E_md_op in 1,2,7,8 with state==BUSY and E_valid), set proto_err and issue nothing.
- proto_err is also set in any cycle where md_busy != (state==BUSY).
- div0 is set in the cycle iss=1 with op 2 or 8 and E_rt==32'h0. The MDU result for that divide is undefined; no trap is raised.
- E_md_rdata is combinational. It is valid only in IDLE with md_start=0, which the stall rule guarantees for mfhi/mflo.
- stall_cnt increments every cycle stall_D=1. 32'hFFFFFFFF wraps to 0.
- Req behaviour:
  - Req does not abort an in-flight operation. The mirror keeps counting, matching the MDU.
  - Req=1 in the would-be start cycle gives no start and no state change.
- Simultaneous events: iss and stall_D can both be 1 in the same cycle. The E instruction completes; D holds.
- Reset (reset=0, asynchronous, mid-operation allowed):
  - state=IDLE, cnt=0, div0=0, proto_err=0, stall_cnt=0.
  - Combinational outputs follow their inputs. The MDU resets on the same signal, so there is no mismatch after reset.

Test Plan:
- mult A=7, B=-3 with E_valid=1 and D_md_use=1 in the same cycle:
  - md_start=1 and md_op=1 for 1 cycle.
  - stall_D=1 for 6 cycles (start + 5).
  - mfhi then returns 0xFFFFFFFF and mflo returns 0xFFFFFFEB.
- divu A=100, B=7 with D_md_use=1: stall_D=1 for 11 cycles, then HI=2 and LO=14.
- div with B=0: div0=1 and stays 1 until reset. Busy lasts 10 cycles. proto_err stays 0.
- Req=1 with a mult in E: md_start=0, md_op=0, state stays IDLE, no stall. Same check for mtlo A=0x55: md_op=0, so LO is unchanged.
- Reset taken at cycle 3 of a div: all registers clear immediately. stall_D=0 once D_md_use drops. A new mult issues cleanly and proto_err=0.
- Preload stall_cnt near 0xFFFFFFFE via 3 stall cycles: the value wraps to 1. Force md_busy=1 while IDLE: proto_err=1.

Source files
------------

// File: rtl/md_issue_ctrl.sv
// MDU issue controller: decodes the E-stage MDU op into start/op/operands,
// mirrors MDU occupancy with a countdown and raises the D-stage stall.
module md_issue_ctrl #(
    parameter int LAT_MUL = 5,
    parameter int LAT_DIV = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        E_valid,
    input  logic [3:0]  E_md_op,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic        D_md_use,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        md_start,
    output logic [3:0]  md_op,
    output logic [31:0] md_A,
    output logic [31:0] md_B,
    output logic        stall_D,
    output logic [31:0] E_md_rdata,
    output logic        div0,
    output logic        proto_err,
    output logic [31:0] stall_cnt
);
    localparam int LAT_MAX = (LAT_DIV > LAT_MUL) ? LAT_DIV : LAT_MUL;
    localparam int CW      = $clog2(LAT_MAX + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          e_go, is_mul, is_div, is_cmd, busy, iss;

    assign e_go   = E_valid & ~Req;
    assign is_mul = (E_md_op == 4'd1) | (E_md_op == 4'd7);
    assign is_div = (E_md_op == 4'd2) | (E_md_op == 4'd8);
    assign is_cmd = is_mul | is_div;
    assign busy   = (state == BUSY);
    assign iss    = e_go & is_cmd & ~busy;

    assign md_start = iss;
    assign md_op    = e_go ? E_md_op : 4'd0;
    assign md_A     = E_rs;
    assign md_B     = E_rt;
    // The start cycle stalls too: md_busy is not up yet and HI/LO still read 0.
    assign stall_D  = D_md_use & (iss | busy);

    always_comb begin
        E_md_rdata = 32'h0;
        case (E_md_op)
            4'd5:    E_md_rdata = md_hi;
            4'd6:    E_md_rdata = md_lo;
            default: E_md_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            div0      <= 1'b0;
            proto_err <= 1'b0;
            stall_cnt <= 32'h0;
        end else begin
            case (state)
                IDLE: if (iss) begin
                    state <= BUSY;
                    cnt   <= is_div ? CW'(LAT_DIV) : CW'(LAT_MUL);
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= IDLE;
                end
            endcase
            if (iss & is_div & (E_rt == 32'h0)) div0 <= 1'b1;
            // Either an op arriving while occupied or the MDU disagreeing with the mirror.
            if ((E_valid & is_cmd & busy) | (md_busy != busy)) proto_err <= 1'b1;
            stall_cnt <= stall_cnt + {31'h0, stall_D};
        end
    end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: behavioural MDU plus directed scenarios and a
// randomized run checked against a cycle-stamp reference model.
module tb_md_issue_ctrl;
    localparam int LAT_MUL = 5;
    localparam int LAT_DIV = 10;

    logic        clk = 1'b0, reset = 1'b0, Req = 1'b0, E_valid = 1'b0, D_md_use = 1'b0;
    logic [3:0]  E_md_op = 4'd0;
    logic [31:0] E_rs = 32'h0, E_rt = 32'h0;
    logic        md_busy, force_busy = 1'b0;
    logic [31:0] md_hi, md_lo;
    logic        md_start, stall_D, div0, proto_err;
    logic [3:0]  md_op;
    logic [31:0] md_A, md_B, E_md_rdata, stall_cnt;
    int          errors = 0, checks = 0;

    md_issue_ctrl #(.LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)) dut (
        .clk(clk), .reset(reset), .Req(Req), .E_valid(E_valid), .E_md_op(E_md_op),
        .E_rs(E_rs), .E_rt(E_rt), .D_md_use(D_md_use), .md_busy(md_busy),
        .md_hi(md_hi), .md_lo(md_lo), .md_start(md_start), .md_op(md_op),
        .md_A(md_A), .md_B(md_B), .stall_D(stall_D), .E_md_rdata(E_md_rdata),
        .div0(div0), .proto_err(proto_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural MDU: result is hidden while busy, busy rises the cycle after start.
    function automatic logic [63:0] mdu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = $signed(a), sb = $signed(b);
        longint unsigned ua = a, ub = b;
        case (op)
            4'd1: return 64'(sa * sb);
            4'd7: return ua * ub;
            4'd2: return (b == 0) ? 64'h0 : {32'(sa % sb), 32'(sa / sb)};
            4'd8: return (b == 0) ? 64'h0 : {32'(ua % ub), 32'(ua / ub)};
            default: return 64'h0;
        endcase
    endfunction

    int          mdu_rem;
    logic [31:0] hi_q, lo_q;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdu_rem <= 0; hi_q <= 32'h0; lo_q <= 32'h0;
        end else if (md_start) begin
            mdu_rem <= (md_op == 4'd2 || md_op == 4'd8) ? LAT_DIV : LAT_MUL;
            {hi_q, lo_q} <= mdu_calc(md_op, md_A, md_B);
        end else begin
            if (mdu_rem > 0) mdu_rem <= mdu_rem - 1;
            if (md_op == 4'd3) hi_q <= md_A;
            if (md_op == 4'd4) lo_q <= md_A;
        end
    end
    assign md_busy = (mdu_rem != 0) || force_busy;
    assign md_hi   = (md_busy || md_start) ? 32'h0 : hi_q;
    assign md_lo   = (md_busy || md_start) ? 32'h0 : lo_q;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; Req = 1'b0; E_valid = 1'b0; E_md_op = 4'd0; D_md_use = 1'b0; force_busy = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Caller sets inputs at a negedge; E is bubbled after the first cycle.
    task automatic run_cycles(input int n, output int stalls, output int starts);
        stalls = 0; starts = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            stalls += int'(stall_D);
            starts += int'(md_start);
            @(posedge clk); @(negedge clk);
            E_valid = 1'b0; E_md_op = 4'd0;
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic duse);
        E_valid = 1'b1; E_md_op = op; E_rs = a; E_rt = b; D_md_use = duse;
    endtask

    task automatic test_reset();
        issue(4'd1, 32'h11, 32'h22, 1'b1);
        #1;
        checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL rst_start: got %0d want 1", md_start); end
        checks++; if (md_op !== 4'd1) begin errors++; $display("FAIL rst_op: got %0d want 1", md_op); end
        checks++; if (md_A !== 32'h11 || md_B !== 32'h22) begin errors++; $display("FAIL rst_operands: got %h/%h want 11/22", md_A, md_B); end
        @(posedge clk); #1;
        checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL rst_stall_cnt: got %h want 0", stall_cnt); end
        checks++; if (div0 !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL rst_sticky: got %0d/%0d want 0/0", div0, proto_err); end
        checks++; if (stall_D !== 1'b1) begin errors++; $display("FAIL rst_stall_idle: got %0d want 1", stall_D); end
        do_reset();
    endtask

    task automatic test_mult();
        int st, sn;
        do_reset();
        issue(4'd1, 32'd7, -32'sd3, 1'b1);
        run_cycles(12, st, sn);
        checks++; if (sn !== 1) begin errors++; $display("FAIL mult_starts: got %0d want 1", sn); end
        checks++; if (st !== 6) begin errors++; $display("FAIL mult_stalls: got %0d want 6", st); end
        issue(4'd5, 32'h0, 32'h0, 1'b1); #1;
        checks++; if (stall_D !== 1'b0) begin errors++; $display("FAIL mult_mfhi_stall: got %0d want 0", stall_D); end
        checks++; if (E_md_rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_mfhi: got %h want ffffffff", E_md_rdata); end
        @(posedge clk); @(negedge clk);
        issue(4'd6, 32'h0, 32'h0, 1'b0); #1;
        checks++; if (E_md_rdata !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_mflo: got %h want ffffffeb", E_md_rdata); end
        checks++; if (stall_cnt !== 32'd6) begin errors++; $display("FAIL mult_stall_cnt: got %0d want 6", stall_cnt); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL mult_proto: got %0d want 0", proto_err); end
    endtask

    task automatic test_divu();
        int st, sn;
        do_reset();
        issue(4'd8, 32'd100, 32'd7, 1'b1);
        run_cycles(16, st, sn);
        checks++; if (st !== 11) begin errors++; $display("FAIL divu_stalls: got %0d want 11", st); end
        issue(4'd5, 32'h0, 32'h0, 1'b0); #1;
        checks++; if (E_md_rdata !== 32'd2) begin errors++; $display("FAIL divu_hi: got %0d want 2", E_md_rdata); end
        @(negedge clk);
        issue(4'd6, 32'h0, 32'h0, 1'b0); #1;
        checks++; if (E_md_rdata !== 32'd14) begin errors++; $display("FAIL divu_lo: got %0d want 14", E_md_rdata); end
        checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL divu_div0: got %0d want 0", div0); end
    endtask

    task automatic test_div0();
        int st, sn;
        do_reset();
        issue(4'd2, 32'd9, 32'd0, 1'b1);
        run_cycles(15, st, sn);
        checks++; if (st !== 11) begin errors++; $display("FAIL div0_stalls: got %0d want 11", st); end
        checks++; if (div0 !== 1'b1) begin errors++; $display("FAIL div0_set: got %0d want 1", div0); end
        D_md_use = 1'b0;
        run_cycles(4, st, sn);
        checks++; if (div0 !== 1'b1) begin errors++; $display("FAIL div0_sticky: got %0d want 1", div0); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL div0_proto: got %0d want 0", proto_err); end
    endtask

    task automatic test_req();
        int st, sn;
        do_reset();
        Req = 1'b1; issue(4'd1, 32'd3, 32'd4, 1'b1); #1;
        checks++; if (md_start !== 1'b0 || md_op !== 4'd0) begin errors++; $display("FAIL req_mult: got start=%0d op=%0d want 0/0", md_start, md_op); end
        checks++; if (stall_D !== 1'b0) begin errors++; $display("FAIL req_stall: got %0d want 0", stall_D); end
        @(negedge clk); Req = 1'b0; E_valid = 1'b0; #1;
        checks++; if (stall_D !== 1'b0) begin errors++; $display("FAIL req_idle: got %0d want 0", stall_D); end
        issue(4'd4, 32'h12345678, 32'h0, 1'b0); #1;
        checks++; if (md_op !== 4'd4) begin errors++; $display("FAIL req_mtlo_op: got %0d want 4", md_op); end
        @(negedge clk); Req = 1'b1; issue(4'd4, 32'h55, 32'h0, 1'b0); #1;
        checks++; if (md_op !== 4'd0) begin errors++; $display("FAIL req_mtlo_blocked: got %0d want 0", md_op); end
        @(negedge clk); Req = 1'b0; issue(4'd6, 32'h0, 32'h0, 1'b0); #1;
        checks++; if (E_md_rdata !== 32'h12345678) begin errors++; $display("FAIL req_lo_kept: got %h want 12345678", E_md_rdata); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL req_proto: got %0d want 0", proto_err); end
        run_cycles(1, st, sn);
    endtask

    task automatic test_reset_mid();
        int st, sn;
        do_reset();
        issue(4'd2, 32'd50, 32'd0, 1'b1);
        run_cycles(3, st, sn);
        #1;
        checks++; if (stall_cnt !== 32'd3 || div0 !== 1'b1) begin errors++; $display("FAIL rmid_pre: got cnt=%0d div0=%0d want 3/1", stall_cnt, div0); end
        reset = 1'b0; #1;
        checks++; if (stall_cnt !== 32'd0 || div0 !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL rmid_clear: got cnt=%0d div0=%0d perr=%0d want 0/0/0", stall_cnt, div0, proto_err); end
        checks++; if (stall_D !== 1'b0) begin errors++; $display("FAIL rmid_stall: got %0d want 0", stall_D); end
        @(negedge clk); reset = 1'b1;
        issue(4'd1, 32'd2, 32'd3, 1'b1);
        run_cycles(10, st, sn);
        checks++; if (st !== 6 || sn !== 1) begin errors++; $display("FAIL rmid_mult: got stalls=%0d starts=%0d want 6/1", st, sn); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rmid_proto: got %0d want 0", proto_err); end
    endtask

    task automatic test_wrap_proto();
        int st, sn;
        do_reset();
        force dut.stall_cnt = 32'hFFFFFFFE;
        @(posedge clk); @(negedge clk);
        release dut.stall_cnt;
        #1;
        checks++; if (stall_cnt !== 32'hFFFFFFFE) begin errors++; $display("FAIL wrap_preload: got %h want fffffffe", stall_cnt); end
        issue(4'd7, 32'd5, 32'd6, 1'b1);
        run_cycles(2, st, sn);
        #1;
        checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h want 0", stall_cnt); end
        run_cycles(1, st, sn);
        #1;
        checks++; if (stall_cnt !== 32'h1) begin errors++; $display("FAIL wrap_one: got %h want 1", stall_cnt); end
        D_md_use = 1'b0;
        issue(4'd2, 32'd1, 32'd1, 1'b0); #1;
        checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL proto_busy_start: got %0d want 0", md_start); end
        @(posedge clk); #1;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_busy_op: got %0d want 1", proto_err); end
        do_reset();
        force_busy = 1'b1;
        @(posedge clk); #1;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_forced_busy: got %0d want 1", proto_err); end
        @(negedge clk); force_busy = 1'b0;
    endtask

    // Reference: occupancy from the cycle stamp of the last issue.
    task automatic test_random();
        int          cyc, st_cyc, lat, r;
        logic        busy_e, cmd, go, s_e, st_e, div0_e, proto_e;
        logic [3:0]  op_e;
        logic [31:0] rd_e, cnt_e;
        do_reset();
        cyc = 0; st_cyc = -100; lat = 0; div0_e = 1'b0; proto_e = 1'b0; cnt_e = 32'h0;
        for (int i = 0; i < 1500; i++) begin
            busy_e = (cyc - st_cyc >= 1) && (cyc - st_cyc <= lat);
            r = $urandom_range(0, 8);
            cmd = (r == 1 || r == 2 || r == 7 || r == 8);
            if (cmd && busy_e && !(i > 1300 && $urandom_range(0, 9) == 0)) r = 0;
            E_md_op = 4'(r);
            E_valid = ($urandom_range(0, 3) != 0);
            Req = ($urandom_range(0, 5) == 0);
            D_md_use = $urandom_range(0, 1) != 0;
            E_rs = $urandom;
            E_rt = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            #1;
            cmd  = (r == 1 || r == 2 || r == 7 || r == 8);
            go   = E_valid && !Req;
            s_e  = go && cmd && !busy_e;
            op_e = go ? 4'(r) : 4'd0;
            st_e = D_md_use && (s_e || busy_e);
            rd_e = (r == 5) ? md_hi : (r == 6) ? md_lo : 32'h0;
            checks++; if (md_start !== s_e) begin errors++; $display("FAIL rnd_start @%0d: got %0d want %0d", i, md_start, s_e); end
            checks++; if (md_op !== op_e) begin errors++; $display("FAIL rnd_op @%0d: got %0d want %0d", i, md_op, op_e); end
            checks++; if (stall_D !== st_e) begin errors++; $display("FAIL rnd_stall @%0d: got %0d want %0d", i, stall_D, st_e); end
            checks++; if (E_md_rdata !== rd_e) begin errors++; $display("FAIL rnd_rdata @%0d: got %h want %h", i, E_md_rdata, rd_e); end
            checks++; if (md_A !== E_rs || md_B !== E_rt) begin errors++; $display("FAIL rnd_operands @%0d: got %h/%h want %h/%h", i, md_A, md_B, E_rs, E_rt); end
            if (s_e && (r == 2 || r == 8) && E_rt == 32'h0) div0_e = 1'b1;
            if ((E_valid && cmd && busy_e) || (md_busy != busy_e)) proto_e = 1'b1;
            cnt_e = cnt_e + (st_e ? 32'd1 : 32'd0);
            if (s_e) begin st_cyc = cyc; lat = (r == 2 || r == 8) ? LAT_DIV : LAT_MUL; end
            @(posedge clk); cyc++; #1;
            checks++; if (div0 !== div0_e) begin errors++; $display("FAIL rnd_div0 @%0d: got %0d want %0d", i, div0, div0_e); end
            checks++; if (proto_err !== proto_e) begin errors++; $display("FAIL rnd_proto @%0d: got %0d want %0d", i, proto_err, proto_e); end
            checks++; if (stall_cnt !== cnt_e) begin errors++; $display("FAIL rnd_stall_cnt @%0d: got %0d want %0d", i, stall_cnt, cnt_e); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divu();
        test_div0();
        test_req();
        test_reset_mid();
        test_wrap_proto();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end
endmodule
